speck_ks_round_unit: RTL and testbench
======================================

// Module: speck_ks_round_unit
// PURPOSE
// - SPECK128/128 step unit: one key-schedule step engine and one inverse (decrypt) round engine.
// - The two engines are independent and share only the clock and reset.
// - The decrypt controller chains 32 instances: key steps first, then inverse rounds with subkeys in reverse order.
// PARAMETERS
// - WORD_SIZE  64  SPECK word width n; block and key are 2*n. Only 64 is verified.
// - ALPHA      8   right-rotate amount (key step and round).
// - BETA       3   left-rotate amount (key step and round).
// PORTS
// - clk            in   1     rising-edge clock
// - rst            in   1     asynchronous, active-high reset
// - ks_start       in   1     start one key-schedule step
// - ks_key_in      in   2W    {k_i[2W-1:W], l_i[W-1:0]}
// - ks_round_ctr   in   W     round index i, XORed into the l update
// - ks_key_out     out  2W    {k_i+1, l_i+1}; [2W-1:W] is the round subkey
// - ks_finished    out  1     one-cycle done pulse
// - ks_state       out  4     key-step FSM state (debug)
// - rd_start       in   1     start one inverse round
// - rd_subkey      in   W     round key k
// - rd_ciphertext  in   2W    {x[2W-1:W], y[W-1:0]}
// - rd_plaintext   out  2W    {x', y'}
// - rd_finished    out  1     one-cycle done pulse
// - rd_state       out  4     round FSM state (debug)
// BEHAVIOUR
// - Reset: all outputs 0 and both FSMs in IDLE. Reset is asynchronous and may arrive mid-operation.
// - FSM states, identical for each engine: IDLE=4'd0, LOAD=4'd1, COMPUTE=4'd2, DONE=4'd3.
// - IDLE: on start=1 at a clock edge, go to LOAD.
// - LOAD: capture all data inputs into internal registers. Inputs may change after this edge.
// - COMPUTE: write the result register.
// - DONE: finished=1 for exactly this cycle, then return to IDLE.
// - Latency: start sampled at edge N -> finished high during cycle N+3. Result is valid from edge N+2.
// - Outputs hold their last result until the next COMPUTE or reset.
// - Start while not in IDLE is ignored and is not queued.
// - Holding start high gives a new operation every 4 cycles.
// - Key step, all arithmetic mod 2^W:
//   l' = (k + ROR(l,ALPHA)) ^ ctr
//   k' = ROL(k,BETA) ^ l'
//   ks_key_out = {k', l'}
// - Inverse round:
//   y' = ROR(x ^ y, BETA)
//   x' = ROL((x ^ k) - y', ALPHA)
//   Subtraction wraps mod 2^W.
// - Rotates are pure bit rotations; wrap-around bits are never lost.
// - Reset during LOAD, COMPUTE or DONE aborts the operation. No finished pulse is produced.
// - Simultaneous ks_start and rd_start: both engines run concurrently with no interaction.
// CONFIGURATION
// - SPECK_STATE_DEBUG_EN defined: ks_state and rd_state drive the FSM encodings above.
// - SPECK_STATE_DEBUG_EN undefined: ks_state and rd_state are tied to 4'h0. Timing and data are otherwise identical.
// TESTING
// - Key step (official SPECK128/128 key):
//   key_in={0706050403020100,0f0e0d0c0b0a0908}, ctr=0
//   -> key_out={37253b31171d0309,0f1513110f0d0b09}, finished at start+3.
// - Inverse round, basic: ct={1,9}, k=0 -> pt={0,1}.
// - Inverse round, key applied: ct={ff,ff}, k=ff -> pt={0,0}.
// - Inverse round, rotate wrap: ct={0100000000000000,0100000000000000}, k=0 -> pt={1,0}.
// - Start while busy: pulse rd_start again at start+1 -> exactly one rd_finished pulse, at start+3.
// - Reset mid-operation: assert rst at start+2 -> outputs 0, state 0, no finished pulse.
//   Then a new start completes normally.

Source files
------------

// File: rtl/speck_ks_round_unit.sv
// rtl/speck_ks_round_unit.sv - SPECK128/128 key-schedule step and inverse round engines
// Optional debug visibility of FSM states: define SPECK_STATE_DEBUG_EN.
module speck_ks_round_unit #(
  parameter int WORD_SIZE = 64,
  parameter int ALPHA     = 8,
  parameter int BETA      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ks_start,
  input  logic [2*WORD_SIZE-1:0]   ks_key_in,
  input  logic [WORD_SIZE-1:0]     ks_round_ctr,
  output logic [2*WORD_SIZE-1:0]   ks_key_out,
  output logic                     ks_finished,
  output logic [3:0]               ks_state,
  input  logic                     rd_start,
  input  logic [WORD_SIZE-1:0]     rd_subkey,
  input  logic [2*WORD_SIZE-1:0]   rd_ciphertext,
  output logic [2*WORD_SIZE-1:0]   rd_plaintext,
  output logic                     rd_finished,
  output logic [3:0]               rd_state
);

  localparam int W = WORD_SIZE;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    COMPUTE = 4'd2,
    DONE    = 4'd3
  } state_t;

  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int a);
    return (v >> a) | (v << (W - a));
  endfunction

  function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int a);
    return (v << a) | (v >> (W - a));
  endfunction

  state_t         ks_st;
  logic [W-1:0]   ks_k;
  logic [W-1:0]   ks_l;
  logic [W-1:0]   ks_ctr;
  logic [W-1:0]   ks_l_next;
  logic [W-1:0]   ks_k_next;

  state_t         rd_st;
  logic [W-1:0]   rd_x;
  logic [W-1:0]   rd_y;
  logic [W-1:0]   rd_k;
  logic [W-1:0]   rd_x_next;
  logic [W-1:0]   rd_y_next;

  // Key step datapath from the captured operands; l' feeds k'.
  always_comb begin
    ks_l_next = (ks_k + ror(ks_l, ALPHA)) ^ ks_ctr;
    ks_k_next = rol(ks_k, BETA) ^ ks_l_next;
  end

  // Inverse round datapath; y' must be formed first because x' subtracts it.
  always_comb begin
    rd_y_next = ror(rd_x ^ rd_y, BETA);
    rd_x_next = rol((rd_x ^ rd_k) - rd_y_next, ALPHA);
  end

  // Key-step sequencer: capture in LOAD, write result in COMPUTE, pulse in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_st       <= IDLE;
      ks_k        <= '0;
      ks_l        <= '0;
      ks_ctr      <= '0;
      ks_key_out  <= '0;
      ks_finished <= 1'b0;
    end else begin
      ks_finished <= 1'b0;
      case (ks_st)
        IDLE: if (ks_start) ks_st <= LOAD;
        LOAD: begin
          ks_k   <= ks_key_in[2*W-1:W];
          ks_l   <= ks_key_in[W-1:0];
          ks_ctr <= ks_round_ctr;
          ks_st  <= COMPUTE;
        end
        COMPUTE: begin
          ks_key_out  <= {ks_k_next, ks_l_next};
          ks_finished <= 1'b1;
          ks_st       <= DONE;
        end
        DONE:    ks_st <= IDLE;
        default: ks_st <= IDLE;
      endcase
    end
  end

  // Inverse-round sequencer, same timing as the key step but fully separate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_st        <= IDLE;
      rd_x         <= '0;
      rd_y         <= '0;
      rd_k         <= '0;
      rd_plaintext <= '0;
      rd_finished  <= 1'b0;
    end else begin
      rd_finished <= 1'b0;
      case (rd_st)
        IDLE: if (rd_start) rd_st <= LOAD;
        LOAD: begin
          rd_x  <= rd_ciphertext[2*W-1:W];
          rd_y  <= rd_ciphertext[W-1:0];
          rd_k  <= rd_subkey;
          rd_st <= COMPUTE;
        end
        COMPUTE: begin
          rd_plaintext <= {rd_x_next, rd_y_next};
          rd_finished  <= 1'b1;
          rd_st        <= DONE;
        end
        DONE:    rd_st <= IDLE;
        default: rd_st <= IDLE;
      endcase
    end
  end

`ifdef SPECK_STATE_DEBUG_EN
  assign ks_state = ks_st;
  assign rd_state = rd_st;
`else
  assign ks_state = 4'h0;
  assign rd_state = 4'h0;
`endif

endmodule

// File: tb/tb_speck_ks_round_unit.sv
// tb/tb_speck_ks_round_unit.sv - directed vector bench for speck_ks_round_unit
module tb_speck_ks_round_unit;

  logic         clk;
  logic         rst;
  logic         ks_start;
  logic [127:0] ks_key_in;
  logic [63:0]  ks_round_ctr;
  logic [127:0] ks_key_out;
  logic         ks_finished;
  logic [3:0]   ks_state;
  logic         rd_start;
  logic [63:0]  rd_subkey;
  logic [127:0] rd_ciphertext;
  logic [127:0] rd_plaintext;
  logic         rd_finished;
  logic [3:0]   rd_state;

  int n_checks;
  int n_fail;

`ifdef SPECK_STATE_DEBUG_EN
  localparam logic [3:0] DONE_ST = 4'd3;
`else
  localparam logic [3:0] DONE_ST = 4'd0;
`endif

  speck_ks_round_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ks_start      (ks_start),
    .ks_key_in     (ks_key_in),
    .ks_round_ctr  (ks_round_ctr),
    .ks_key_out    (ks_key_out),
    .ks_finished   (ks_finished),
    .ks_state      (ks_state),
    .rd_start      (rd_start),
    .rd_subkey     (rd_subkey),
    .rd_ciphertext (rd_ciphertext),
    .rd_plaintext  (rd_plaintext),
    .rd_finished   (rd_finished),
    .rd_state      (rd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  ctr;
    logic [127:0] exp;
  } ks_vec_t;

  typedef struct {
    logic [127:0] ct;
    logic [63:0]  k;
    logic [127:0] exp;
  } rd_vec_t;

  ks_vec_t ks_tab [4];
  rd_vec_t rd_tab [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the key engine idle; ends just after a negedge.
  task automatic ks_op(input logic [127:0] key, input logic [63:0] ctr, input logic [127:0] exp);
    ks_key_in = key; ks_round_ctr = ctr; ks_start = 1'b1;
    @(posedge clk); #1 ks_start = 1'b0;
    @(posedge clk); #1 ks_key_in = ~key; ks_round_ctr = ~ctr;
    @(negedge clk);
    chk("ks_fin_early", {127'd0, ks_finished}, 128'd0);
    @(negedge clk);
    chk("ks_fin", {127'd0, ks_finished}, 128'd1);
    chk("ks_key_out", ks_key_out, exp);
    chk("ks_state_done", {124'd0, ks_state}, {124'd0, DONE_ST});
    @(negedge clk);
    chk("ks_fin_drop", {127'd0, ks_finished}, 128'd0);
    chk("ks_key_hold", ks_key_out, exp);
  endtask

  task automatic rd_op(input logic [127:0] ct, input logic [63:0] k, input logic [127:0] exp);
    rd_ciphertext = ct; rd_subkey = k; rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    @(posedge clk); #1 rd_ciphertext = ~ct; rd_subkey = ~k;
    @(negedge clk);
    chk("rd_fin_early", {127'd0, rd_finished}, 128'd0);
    @(negedge clk);
    chk("rd_fin", {127'd0, rd_finished}, 128'd1);
    chk("rd_plaintext", rd_plaintext, exp);
    chk("rd_state_done", {124'd0, rd_state}, {124'd0, DONE_ST});
    @(negedge clk);
    chk("rd_fin_drop", {127'd0, rd_finished}, 128'd0);
    chk("rd_pt_hold", rd_plaintext, exp);
  endtask

  initial begin
    int cnt;
    int first;
    n_checks = 0;
    n_fail   = 0;

    ks_tab[0] = '{128'h0706050403020100_0f0e0d0c0b0a0908, 64'h0, 128'h37253b31171d0309_0f1513110f0d0b09};
    ks_tab[1] = '{128'h0, 64'h5, 128'h0000000000000005_0000000000000005};
    ks_tab[2] = '{128'h0000000000000000_00000000000000ff, 64'h0, 128'hff00000000000000_ff00000000000000};
    ks_tab[3] = '{128'he000000000000000_0000000000000000, 64'h1, 128'he000000000000006_e000000000000001};

    rd_tab[0] = '{128'h1_0000000000000009, 64'h0, 128'h0_0000000000000001};
    rd_tab[1] = '{128'hff_00000000000000ff, 64'hff, 128'h0};
    rd_tab[2] = '{128'h0100000000000000_0100000000000000, 64'h0, 128'h0000000000000001_0000000000000000};
    rd_tab[3] = '{128'h0_0000000000000001, 64'h0, 128'h00000000000000e0_2000000000000000};
    rd_tab[4] = '{128'h0, 64'h5, 128'h0000000000000500_0000000000000000};

    rst = 1'b1; ks_start = 1'b0; rd_start = 1'b0;
    ks_key_in = '0; ks_round_ctr = '0; rd_subkey = '0; rd_ciphertext = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ks_out", ks_key_out, 128'd0);
    chk("rst_rd_out", rd_plaintext, 128'd0);
    chk("rst_flags", {124'd0, ks_finished, rd_finished, 2'b00}, 128'd0);
    chk("rst_states", {120'd0, ks_state, rd_state}, 128'd0);

    for (int i = 0; i < 4; i++) ks_op(ks_tab[i].key, ks_tab[i].ctr, ks_tab[i].exp);
    for (int i = 0; i < 5; i++) rd_op(rd_tab[i].ct, rd_tab[i].k, rd_tab[i].exp);

    // Both engines started together must each produce their own result.
    ks_key_in = ks_tab[0].key; ks_round_ctr = ks_tab[0].ctr;
    rd_ciphertext = rd_tab[3].ct; rd_subkey = rd_tab[3].k;
    ks_start = 1'b1; rd_start = 1'b1;
    @(posedge clk); #1 ks_start = 1'b0; rd_start = 1'b0;
    @(posedge clk); #1 ks_key_in = '0; rd_ciphertext = '0;
    @(negedge clk);
    @(negedge clk);
    chk("conc_fin", {126'd0, ks_finished, rd_finished}, 128'd3);
    chk("conc_ks", ks_key_out, ks_tab[0].exp);
    chk("conc_rd", rd_plaintext, rd_tab[3].exp);
    @(negedge clk);

    // Second start one cycle after the first is ignored: one pulse only.
    rd_ciphertext = rd_tab[0].ct; rd_subkey = rd_tab[0].k; rd_start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rd_start = 1'b0;
    cnt = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_finished) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("busy_pulse_count", 128'(cnt), 128'd1);
    chk("busy_pulse_time", 128'(first), 128'd1);
    chk("busy_pt", rd_plaintext, rd_tab[0].exp);

    // Reset during COMPUTE aborts both outputs and suppresses the pulse.
    rd_ciphertext = rd_tab[3].ct; rd_subkey = rd_tab[3].k; rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_rd_out", rd_plaintext, 128'd0);
    chk("midrst_ks_out", ks_key_out, 128'd0);
    chk("midrst_state", {120'd0, ks_state, rd_state}, 128'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_finished || ks_finished) cnt++;
    end
    chk("midrst_no_pulse", 128'(cnt), 128'd0);
    chk("midrst_rd_hold0", rd_plaintext, 128'd0);

    rd_op(rd_tab[2].ct, rd_tab[2].k, rd_tab[2].exp);
    ks_op(ks_tab[0].key, ks_tab[0].ctr, ks_tab[0].exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
